// File: rtl/circle_sort_arb.sv
// circle_sort_arb: shares one rotate-sum-sort engine between two requesters.
// Each grant buffers a 16-pixel frame, replays it to the engine as a single
// contiguous burst, collects the 8 sorted results and hands them back through
// a backpressured response port. The engine is reset if it fails to answer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no frame in flight; arbitrate between requesters
// LOAD    | accept 16 beats from the granted requester into the frame buffer
// ISSUE   | replay frame buffer to engine, 16 back-to-back beats
// WAIT    | wait for first engine result, bounded by TIMEOUT cycles
// CAPTURE | store results 1..7 on consecutive cycles
// DRAIN   | return 8 results to owning requester, honouring resp_ready
// ABORT   | one-cycle engine reset and error pulse; frame discarded
module circle_sort_arb #(
    parameter int TIMEOUT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [9:0] req_data,
    input  logic [5:0] req_c1,
    input  logic [5:0] req_c2,
    output logic       eng_in_valid,
    output logic [4:0] eng_in,
    output logic [2:0] eng_circle1,
    output logic [2:0] eng_circle2,
    output logic       eng_rst_n,
    input  logic [5:0] eng_out,
    input  logic       eng_out_valid,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [5:0] resp_data,
    output logic       resp_last,
    output logic       err_timeout,
    output logic       err_id
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic [3:0]      idx_q, idx_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [2:0]      c1_q, c1_d, c2_q, c2_d;
    logic [4:0]      frame_q [16];
    logic [4:0]      frame_d [16];
    logic [5:0]      res_q [8];
    logic [5:0]      res_d [8];

    logic [1:0]      req_ready_q, req_ready_d;
    logic            eng_in_valid_q, eng_in_valid_d;
    logic [4:0]      eng_in_q, eng_in_d;
    logic [2:0]      eng_circle1_q, eng_circle1_d;
    logic [2:0]      eng_circle2_q, eng_circle2_d;
    logic            eng_rst_n_q, eng_rst_n_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [5:0]      resp_data_q, resp_data_d;
    logic            resp_last_q, resp_last_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_id_q, err_id_d;

    logic [4:0]      pix_sel;
    logic [2:0]      c1_sel, c2_sel;

    assign pix_sel = grant_q ? req_data[9:5] : req_data[4:0];
    assign c1_sel  = grant_q ? req_c1[5:3]   : req_c1[2:0];
    assign c2_sel  = grant_q ? req_c2[5:3]   : req_c2[2:0];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        logic gnt;
        logic abort;

        gnt            = 1'b0;
        abort          = 1'b0;
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        idx_d          = idx_q;
        wait_d         = wait_q;
        c1_d           = c1_q;
        c2_d           = c2_q;
        frame_d        = frame_q;
        res_d          = res_q;
        req_ready_d    = 2'b00;
        eng_in_valid_d = 1'b0;
        eng_in_d       = 5'd0;
        eng_circle1_d  = 3'd0;
        eng_circle2_d  = 3'd0;
        eng_rst_n_d    = 1'b1;
        resp_valid_d   = 1'b0;
        resp_id_d      = 1'b0;
        resp_data_d    = 6'd0;
        resp_last_d    = 1'b0;
        err_timeout_d  = 1'b0;
        err_id_d       = err_id_q;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    // Contention goes to whoever was not served last.
                    gnt         = (req_valid == 2'b11) ? ~last_q : req_valid[1];
                    grant_d     = gnt;
                    last_d      = gnt;
                    idx_d       = 4'd0;
                    state_d     = S_LOAD;
                    req_ready_d = gnt ? 2'b10 : 2'b01;
                end
            end
            S_LOAD: begin
                req_ready_d = req_ready_q;
                if (req_valid[grant_q] && req_ready_q[grant_q]) begin
                    frame_d[idx_q] = pix_sel;
                    if (idx_q == 4'd0) begin
                        c1_d = c1_sel;
                        c2_d = c2_sel;
                    end
                    if (idx_q == 4'd15) begin
                        state_d        = S_ISSUE;
                        idx_d          = 4'd0;
                        req_ready_d    = 2'b00;
                        eng_in_valid_d = 1'b1;
                        eng_in_d       = frame_q[0];
                        eng_circle1_d  = c1_q;
                        eng_circle2_d  = c2_q;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (idx_q == 4'd15) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end else begin
                    idx_d          = idx_q + 4'd1;
                    eng_in_valid_d = 1'b1;
                    eng_in_d       = frame_q[idx_q + 4'd1];
                end
            end
            S_WAIT: begin
                if (eng_out_valid) begin
                    res_d[0] = eng_out;
                    idx_d    = 4'd1;
                    state_d  = S_CAPTURE;
                end else if (wait_q == WAIT_LAST) begin
                    abort = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!eng_out_valid) begin
                    abort = 1'b1;
                end else begin
                    res_d[idx_q[2:0]] = eng_out;
                    if (idx_q == 4'd7) begin
                        state_d      = S_DRAIN;
                        idx_d        = 4'd0;
                        resp_valid_d = 1'b1;
                        resp_id_d    = grant_q;
                        resp_data_d  = res_q[0];
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                resp_valid_d = 1'b1;
                resp_id_d    = grant_q;
                resp_data_d  = resp_data_q;
                resp_last_d  = resp_last_q;
                if (resp_ready) begin
                    if (idx_q == 4'd7) begin
                        state_d      = S_IDLE;
                        resp_valid_d = 1'b0;
                        resp_id_d    = 1'b0;
                        resp_data_d  = 6'd0;
                        resp_last_d  = 1'b0;
                    end else begin
                        idx_d       = idx_q + 4'd1;
                        resp_data_d = res_q[idx_q[2:0] + 3'd1];
                        resp_last_d = (idx_q == 4'd6);
                    end
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort is entered from WAIT or CAPTURE; outputs land with the state.
        if (abort) begin
            state_d       = S_ABORT;
            err_timeout_d = 1'b1;
            err_id_d      = grant_q;
            eng_rst_n_d   = 1'b0;
        end
    end

    // State, buffers and output registers; reset also holds the engine in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            grant_q        <= 1'b0;
            last_q         <= 1'b1;
            idx_q          <= 4'd0;
            wait_q         <= '0;
            c1_q           <= 3'd0;
            c2_q           <= 3'd0;
            for (int i = 0; i < 16; i++) frame_q[i] <= 5'd0;
            for (int i = 0; i < 8; i++)  res_q[i]   <= 6'd0;
            req_ready_q    <= 2'b00;
            eng_in_valid_q <= 1'b0;
            eng_in_q       <= 5'd0;
            eng_circle1_q  <= 3'd0;
            eng_circle2_q  <= 3'd0;
            eng_rst_n_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_data_q    <= 6'd0;
            resp_last_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_id_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_q         <= last_d;
            idx_q          <= idx_d;
            wait_q         <= wait_d;
            c1_q           <= c1_d;
            c2_q           <= c2_d;
            frame_q        <= frame_d;
            res_q          <= res_d;
            req_ready_q    <= req_ready_d;
            eng_in_valid_q <= eng_in_valid_d;
            eng_in_q       <= eng_in_d;
            eng_circle1_q  <= eng_circle1_d;
            eng_circle2_q  <= eng_circle2_d;
            eng_rst_n_q    <= eng_rst_n_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_data_q    <= resp_data_d;
            resp_last_q    <= resp_last_d;
            err_timeout_q  <= err_timeout_d;
            err_id_q       <= err_id_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign eng_in_valid = eng_in_valid_q;
    assign eng_in       = eng_in_q;
    assign eng_circle1  = eng_circle1_q;
    assign eng_circle2  = eng_circle2_q;
    assign eng_rst_n    = eng_rst_n_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_data    = resp_data_q;
    assign resp_last    = resp_last_q;
    assign err_timeout  = err_timeout_q;
    assign err_id       = err_id_q;

endmodule

// File: tb/tb_circle_sort_arb.sv
// Bench for circle_sort_arb: directed frames, a behavioural engine, and a
// response scoreboard fed at issue time and drained by an independent monitor.
module tb_circle_sort_arb;

    localparam int TIMEOUT = 100;
    localparam int FA = 0;  // pixels 1..16, c1=c2=1
    localparam int FB = 1;  // pixels 0..7 then 31x4, 0x4, c1=c2=0
    localparam int FC = 2;  // pixels 1..16, c1=2, c2=0

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready;
    logic [9:0] req_data;
    logic [5:0] req_c1, req_c2;
    logic       eng_in_valid;
    logic [4:0] eng_in;
    logic [2:0] eng_circle1, eng_circle2;
    logic       eng_rst_n;
    logic [5:0] eng_out;
    logic       eng_out_valid;
    logic       resp_valid, resp_ready, resp_id;
    logic [5:0] resp_data;
    logic       resp_last, err_timeout, err_id;

    logic       v_r   [2];
    logic [4:0] pix_r [2];
    logic [2:0] c1_r  [2];
    logic [2:0] c2_r  [2];

    assign req_valid = {v_r[1], v_r[0]};
    assign req_data  = {pix_r[1], pix_r[0]};
    assign req_c1    = {c1_r[1], c1_r[0]};
    assign req_c2    = {c2_r[1], c2_r[0]};

    circle_sort_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_c1(req_c1), .req_c2(req_c2),
        .eng_in_valid(eng_in_valid), .eng_in(eng_in),
        .eng_circle1(eng_circle1), .eng_circle2(eng_circle2), .eng_rst_n(eng_rst_n),
        .eng_out(eng_out), .eng_out_valid(eng_out_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_last(resp_last),
        .err_timeout(err_timeout), .err_id(err_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_vec = 0;
    int  n_err = 0;
    int  burst_cyc = -1;
    int  last_out_cyc = -100;
    int  n_bursts = 0;
    int  unexp = 0;
    int  beat0_cyc [2];
    bit  eng_mute = 1'b0;
    bit  rmode = 1'b0;

    typedef struct packed {
        logic       id;
        logic [5:0] data;
        logic       last;
    } exp_t;
    exp_t q[$];

    logic [5:0] exp_tab [3][8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] fpix(input int f, input int k);
        logic [4:0] p;
        case (f)
            FB:      p = (k < 8) ? 5'(k) : ((k < 12) ? 5'd31 : 5'd0);
            default: p = 5'(k + 1);
        endcase
        return p;
    endfunction

    function automatic logic [2:0] fc1(input int f);
        return (f == FA) ? 3'd1 : ((f == FC) ? 3'd2 : 3'd0);
    endfunction

    function automatic logic [2:0] fc2(input int f);
        return (f == FA) ? 3'd1 : 3'd0;
    endfunction

    task automatic push_exp(input logic id, input int f);
        exp_t e;
        for (int j = 0; j < 8; j++) begin
            e.id   = id;
            e.data = exp_tab[f][j];
            e.last = (j == 7);
            q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge following the last accept.
    task automatic drive_frame(input int r, input int f, input int stall_at, input int stall_len);
        int guard;
        bit acc;
        c1_r[r] = fc1(f);
        c2_r[r] = fc2(f);
        for (int k = 0; k < 16; k++) begin
            pix_r[r] = fpix(f, k);
            v_r[r]   = 1'b1;
            guard    = 0;
            acc      = 1'b0;
            while (!acc && guard < 2000) begin
                acc = req_ready[r];
                if (acc && k == 0) beat0_cyc[r] = cyc;
                @(negedge clk);
                guard++;
            end
            if (!acc) begin
                chk("req_accept_bound", 0, 1);
                return;
            end
            if (k == stall_at) begin
                v_r[r] = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
        end
    endtask

    task automatic wait_empty(input string name);
        int g;
        g = 0;
        while (q.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk(name, q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},    req_ready, 0);
        chk({tag, "_eng_in_valid"}, eng_in_valid, 0);
        chk({tag, "_eng_in"},       eng_in, 0);
        chk({tag, "_eng_circle1"},  eng_circle1, 0);
        chk({tag, "_eng_circle2"},  eng_circle2, 0);
        chk({tag, "_eng_rst_n"},    eng_rst_n, 0);
        chk({tag, "_resp_valid"},   resp_valid, 0);
        chk({tag, "_resp_data"},    resp_data, 0);
        chk({tag, "_resp_id"},      resp_id, 0);
        chk({tag, "_resp_last"},    resp_last, 0);
        chk({tag, "_err_timeout"},  err_timeout, 0);
        chk({tag, "_err_id"},       err_id, 0);
    endtask

    // Behavioural engine: circle1 = beats 0..7, circle2 = beats 8..15,
    // each rotated by its count, summed pairwise, sorted ascending.
    logic [4:0] px [16];
    logic [5:0] s  [8];
    logic [5:0] tmp;
    int         ec1, ec2;
    bit         ok;

    initial begin
        eng_out_valid = 1'b0;
        eng_out       = 6'd0;
        forever begin
            @(negedge clk);
            if (eng_rst_n && eng_in_valid) begin
                ok        = 1'b1;
                burst_cyc = cyc;
                ec1       = int'(eng_circle1);
                ec2       = int'(eng_circle2);
                px[0]     = eng_in;
                for (int k = 1; k < 16 && ok; k++) begin
                    @(negedge clk);
                    if (!eng_rst_n) begin
                        ok = 1'b0;
                    end else begin
                        chk("burst_contiguous", eng_in_valid, 1);
                        if (!eng_in_valid) begin
                            ok = 1'b0;
                        end else begin
                            px[k] = eng_in;
                            chk("circle1_zero_after_beat0", eng_circle1, 0);
                            chk("circle2_zero_after_beat0", eng_circle2, 0);
                        end
                    end
                end
                if (ok) begin
                    n_bursts++;
                    for (int i = 0; i < 8; i++)
                        s[i] = 6'(px[(i + ec1) % 8]) + 6'(px[8 + ((i + ec2) % 8)]);
                    for (int i = 0; i < 7; i++)
                        for (int j = 0; j < 7 - i; j++)
                            if (s[j] > s[j+1]) begin
                                tmp    = s[j];
                                s[j]   = s[j+1];
                                s[j+1] = tmp;
                            end
                    if (!eng_mute) begin
                        repeat (2) @(negedge clk);
                        for (int i = 0; i < 8; i++) begin
                            eng_out_valid = 1'b1;
                            eng_out       = s[i];
                            last_out_cyc  = cyc;
                            @(negedge clk);
                        end
                        eng_out_valid = 1'b0;
                        eng_out       = 6'd0;
                    end
                end
            end
        end
    end

    // Response monitor: drives resp_ready and checks against the scoreboard.
    bit   tog = 1'b1;
    bit   prev_rv = 1'b0;
    bit   rr;
    exp_t e;

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            rr         = rmode ? tog : 1'b1;
            resp_ready = rr;
            if (resp_valid) begin
                if (!prev_rv) chk("resp_first_latency", cyc - last_out_cyc, 1);
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    unexp++;
                    $display("FAIL unexpected_resp: got data %0d id %0d with nothing outstanding (cycle %0d)",
                             resp_data, resp_id, cyc);
                end else begin
                    e = q[0];
                    chk("resp_id",   resp_id,   e.id);
                    chk("resp_data", resp_data, e.data);
                    chk("resp_last", resp_last, e.last);
                    if (rr) void'(q.pop_front());
                end
                tog = ~tog;
            end else begin
                tog = 1'b1;
            end
            prev_rv = resp_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int ecyc, erst, eid, nb;

    initial begin
        exp_tab[FA] = '{6'd10, 6'd12, 6'd14, 6'd16, 6'd18, 6'd20, 6'd22, 6'd24};
        exp_tab[FB] = '{6'd4,  6'd5,  6'd6,  6'd7,  6'd31, 6'd32, 6'd33, 6'd34};
        exp_tab[FC] = '{6'd12, 6'd14, 6'd16, 6'd16, 6'd18, 6'd18, 6'd20, 6'd22};
        for (int r = 0; r < 2; r++) begin
            v_r[r]   = 1'b0;
            pix_r[r] = 5'd0;
            c1_r[r]  = 3'd0;
            c2_r[r]  = 3'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("eng_rst_n_after_reset", eng_rst_n, 1);

        // Requester 0, unstalled reference frame.
        nb = n_bursts;
        push_exp(1'b0, FA);
        drive_frame(0, FA, -1, 0);
        v_r[0] = 1'b0;
        wait_empty("frame_a_done");
        chk("issue_latency", burst_cyc - beat0_cyc[0], 16);
        chk("frame_a_bursts", n_bursts - nb, 1);

        // Requester 1 stalls 5 cycles after beat 7; same result expected.
        push_exp(1'b1, FA);
        drive_frame(1, FA, 7, 5);
        v_r[1] = 1'b0;
        wait_empty("stall_done");

        // Toggled resp_ready during drain, frame with 0/31 pixels and c=0.
        rmode = 1'b1;
        push_exp(1'b0, FB);
        drive_frame(0, FB, -1, 0);
        v_r[0] = 1'b0;
        wait_empty("toggle_done");
        rmode = 1'b0;

        // Engine never answers: abort exactly TIMEOUT cycles into WAIT.
        eng_mute = 1'b1;
        drive_frame(1, FA, -1, 0);
        v_r[1] = 1'b0;
        ecyc = -1;
        erst = -1;
        eid  = -1;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (err_timeout) begin
                ecyc = cyc;
                erst = int'(eng_rst_n);
                eid  = int'(err_id);
                break;
            end
        end
        chk("timeout_cycle", ecyc - burst_cyc, 16 + TIMEOUT);
        chk("abort_eng_rst_n", erst, 0);
        chk("abort_err_id", eid, 1);
        @(negedge clk);
        chk("err_pulse_width", err_timeout, 0);
        chk("eng_rst_n_release", eng_rst_n, 1);
        chk("err_id_held", err_id, 1);
        eng_mute = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_resp", unexp, 0);

        // Normal grant after the abort.
        push_exp(1'b0, FC);
        drive_frame(0, FC, -1, 0);
        v_r[0] = 1'b0;
        wait_empty("post_abort_done");

        // Reset while beat 9 is on the engine input.
        nb = n_bursts;
        drive_frame(0, FA, -1, 0);
        v_r[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("beat9_pixel", eng_in, 10);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("midreset_no_resp", unexp, 0);
        chk("midreset_queue", q.size(), 0);
        chk("midreset_no_burst", n_bursts - nb, 0);

        // Both requesters valid from reset for 4 frames: grants alternate.
        rst = 1'b1;
        pix_r[0] = fpix(FA, 0);
        pix_r[1] = fpix(FC, 0);
        v_r[0] = 1'b1;
        v_r[1] = 1'b1;
        nb = n_bursts;
        push_exp(1'b0, FA);
        push_exp(1'b1, FC);
        push_exp(1'b0, FB);
        push_exp(1'b1, FA);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            begin
                drive_frame(0, FA, -1, 0);
                drive_frame(0, FB, -1, 0);
                v_r[0] = 1'b0;
            end
            begin
                drive_frame(1, FC, -1, 0);
                drive_frame(1, FA, -1, 0);
                v_r[1] = 1'b0;
            end
        join
        wait_empty("alternate_done");
        chk("alternate_bursts", n_bursts - nb, 4);
        chk("final_no_unexpected", unexp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/circle_sort_arb.md
# circle_sort_arb

Round-robin arbiter and sequencer that shares one circle rotate-sum-sort engine between two requesters. Each requester streams a 16-pixel frame with valid/ready handshaking and may stall. The block buffers the frame and replays it to the engine as the contiguous 16-cycle burst the engine requires. It then captures the engine's 8 sorted results and returns them to the owning requester through a backpressured response port, and recovers the engine on timeout.

## Interface
- TIMEOUT, 100, maximum cycles waited in WAIT for eng_out_valid before abort
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester beat valid (bit i = requester i)
- req_ready  out  2  per-requester beat accept
- req_data  in  10  pixel per requester, {r1[4:0], r0[4:0]}
- req_c1  in  6  circle1 rotate count per requester, {r1[2:0], r0[2:0]}; sampled on beat 0 only
- req_c2  in  6  circle2 rotate count per requester, same packing
- eng_in_valid  out  1  engine input valid
- eng_in  out  5  engine pixel
- eng_circle1, eng_circle2  out  3 each  engine rotate counts; valid on burst beat 0, else 0
- eng_rst_n  out  1  engine active-low reset
- eng_out  in  6  engine result
- eng_out_valid  in  1  engine result valid
- resp_valid  out  1  result valid
- resp_ready  in  1  result accept
- resp_id  out  1  owning requester
- resp_data  out  6  sorted sum
- resp_last  out  1  high on 8th result
- err_timeout  out  1  one-cycle pulse on abort
- err_id  out  1  requester whose frame was aborted; held until next abort

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, CAPTURE, DRAIN, ABORT.
- IDLE: if any req_valid, register the grant and go to LOAD. Both valid: grant goes to the requester not granted last. After reset, requester 0 has priority.
- LOAD: req_ready[g]=1 and the other bit is 0. A beat is accepted on req_valid[g]&req_ready[g] into buf[k], k=0..15. req_c1/req_c2 of g are captured on k=0. The 16th accept moves to ISSUE. Stalls of any length are allowed.
- ISSUE: exactly 16 consecutive cycles with eng_in_valid=1 and eng_in=buf[k]. eng_circle1/2 carry the captured counts on k=0 and 0 on other beats. Then WAIT.
- WAIT: a wait counter increments each cycle. eng_out_valid=1 moves to CAPTURE and stores that cycle's eng_out as res[0]. Counter reaching TIMEOUT with no valid goes to ABORT.
- CAPTURE: stores eng_out into res[1..7] on consecutive cycles. If eng_out_valid drops before 8 results are stored, go to ABORT. After 8 results, go to DRAIN.
- DRAIN: resp_valid=1, resp_data=res[j], resp_id=g, resp_last=(j==7). j advances on resp_ready. The handshake at j==7 returns to IDLE. DRAIN always lasts at least 8 cycles, which guarantees the engine's post-output idle gap.
- ABORT: one cycle. eng_rst_n=0, err_timeout=1, err_id=g. The frame is discarded and nothing is returned to the requester. The round-robin pointer advances as if the frame completed. Next state is IDLE.
- eng_out_valid outside WAIT/CAPTURE is ignored.
- Widths: pixels 5-bit, results 6-bit. The block never modifies data; pixel values 0 and 31 and circle value 0 pass through unchanged.

## Timing
- Reset values: req_ready=0, eng_in_valid=0, eng_in=0, eng_circle1/2=0, resp_valid=0, resp_data=0, resp_id=0, resp_last=0, err_timeout=0, err_id=0.
- eng_rst_n is 0 while rst=1, then 1.
- Reset mid-operation: the next state is IDLE. The partial frame, buffered results and RR pointer are cleared, and the engine is reset.
- All outputs are registered.
- Grant latency: req_valid rising in IDLE gives req_ready at the next edge.
- Best case, beat 0 accepted at cycle T: eng_in_valid covers T+16..T+31, and WAIT starts at T+32.
- First resp_valid is exactly 1 cycle after res[7] is captured.
- Zero-stall drain takes 8 cycles. Back-to-back frames need 1 IDLE cycle for the next grant.
- Only one frame is in flight; no request is accepted outside LOAD.

## Test plan
- Requester 0, pixels 1..16, c1=c2=1, no stalls, reference engine model -> resp_id=0, resp_data 10,12,14,16,18,20,22,24, resp_last on 24; eng_in_valid high exactly 16 consecutive cycles with circle values only on beat 0.
- Both requesters assert req_valid continuously from reset for 4 frames -> grants alternate 0,1,0,1; each response set carries the matching resp_id.
- Requester 1 drops req_valid for 5 cycles after beat 7 -> the engine still receives one contiguous 16-beat burst and the result is identical to the unstalled run.
- resp_ready toggled 1,0,1,0 during DRAIN -> resp_data holds while unaccepted, all 8 values delivered in order, no loss or duplication.
- Engine model never raises out_valid -> err_timeout pulse and eng_rst_n low for one cycle exactly TIMEOUT=100 cycles into WAIT; err_id=g; no resp_valid; next request is granted normally.
- rst asserted during ISSUE beat 9 -> next cycle all outputs are at reset values with eng_rst_n=0, and no response is produced for the aborted frame.
